// File: rtl/rv32i_dbus_responder_if.sv
// Data-port bundle between the RV32I core (master) and the data-side responder (slave).
interface rv32i_dbus_responder_if;
    logic        MemWrite;
    logic [31:0] MemAddr;
    logic [31:0] MemWData;
    logic [3:0]  ByteEnable;
    logic [31:0] MemRData;

    modport master (
        output MemWrite,
        output MemAddr,
        output MemWData,
        output ByteEnable,
        input  MemRData
    );

    modport slave (
        input  MemWrite,
        input  MemAddr,
        input  MemWData,
        input  ByteEnable,
        output MemRData
    );
endinterface

// File: rtl/rv32i_dbus_responder.sv
// Data-side responder for a single-cycle RV32I core: word RAM plus MMIO timer/LED block.
// Optional macro DBUS_ERR_CHECK_EN enables the sticky bus_err flag and 32'hDEAD_BEEF unmapped reads.
module rv32i_dbus_responder #(
    parameter int          RAM_AW    = 10,
    parameter logic [31:0] RAM_BASE  = 32'h1000_0000,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
    parameter int          PRESCALE  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    rv32i_dbus_responder_if.slave       bus,
    output logic                        timer_irq,
    output logic [7:0]                  led,
    output logic                        bus_err
);
    localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]  PRE_MAX  = PW'(PRESCALE - 1);
    localparam logic [5:0]     OFF_CNT  = 6'h00;
    localparam logic [5:0]     OFF_CMP  = 6'h01;
    localparam logic [5:0]     OFF_CTRL = 6'h02;
    localparam logic [5:0]     OFF_STAT = 6'h03;
    localparam logic [5:0]     OFF_LED  = 6'h04;
`ifdef DBUS_ERR_CHECK_EN
    localparam logic [31:0]    UNMAPPED_RD = 32'hDEAD_BEEF;
`else
    localparam logic [31:0]    UNMAPPED_RD = 32'h0000_0000;
`endif

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [31:0]        ram_q [2**RAM_AW];
    logic [31:0]        cnt_q, cnt_d;
    logic [31:0]        cmp_q, cmp_d;
    logic [2:0]         ctrl_q, ctrl_d;
    logic               match_q, match_d;
    logic [7:0]         led_q, led_d;
    logic [PW-1:0]      pre_q, pre_d;
    logic               bus_err_q, bus_err_d;

    logic               ram_hit_s, mmio_hit_s, unmapped_s;
    logic [RAM_AW-1:0]  ram_idx_s;
    logic [5:0]         off_s;
    logic               mmio_wr_s, cnt_wr_s, tick_s, hit_s;
    logic [31:0]        rdata_s;
    logic               unused_s;

    assign ram_hit_s  = (bus.MemAddr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2]);
    assign mmio_hit_s = (bus.MemAddr[31:8] == MMIO_BASE[31:8]);
    assign unmapped_s = !ram_hit_s && !mmio_hit_s;
    assign ram_idx_s  = bus.MemAddr[RAM_AW+1:2];
    assign off_s      = bus.MemAddr[7:2];
    assign mmio_wr_s  = bus.MemWrite && mmio_hit_s;
    assign cnt_wr_s   = mmio_wr_s && (off_s == OFF_CNT) && (bus.ByteEnable != 4'b0000);
    assign tick_s     = ctrl_q[0] && (pre_q == PRE_MAX);
    assign hit_s      = tick_s && (cnt_q == cmp_q);
    assign unused_s   = ^bus.MemAddr[1:0];

    // RAM storage: lane-masked writes, contents survive reset, writes dropped while reset is high.
    always_ff @(posedge clk) begin
        if (!reset && bus.MemWrite && ram_hit_s) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.ByteEnable[i]) begin
                    ram_q[ram_idx_s][8*i +: 8] <= bus.MemWData[8*i +: 8];
                end
            end
        end
    end

    // Next-state of the timer, control and LED registers, with CPU writes arbitrated against ticks.
    always_comb begin
        cnt_d   = cnt_q;
        cmp_d   = cmp_q;
        ctrl_d  = ctrl_q;
        match_d = match_q;
        led_d   = led_q;
        pre_d   = pre_q;

        if (cnt_wr_s) begin
            cnt_d = merge_lanes(cnt_q, bus.MemWData, bus.ByteEnable);
        end else if (hit_s) begin
            cnt_d = ctrl_q[1] ? 32'h0000_0000 : cnt_q + 32'h0000_0001;
        end else if (tick_s) begin
            cnt_d = cnt_q + 32'h0000_0001;
        end else begin
            cnt_d = cnt_q;
        end

        if (mmio_wr_s && (off_s == OFF_CMP)) begin
            cmp_d = merge_lanes(cmp_q, bus.MemWData, bus.ByteEnable);
        end else begin
            cmp_d = cmp_q;
        end

        if (mmio_wr_s && (off_s == OFF_CTRL) && bus.ByteEnable[0]) begin
            ctrl_d = bus.MemWData[2:0];
        end else begin
            ctrl_d = ctrl_q;
        end

        // A match set in the same edge beats a write-1-to-clear.
        if (hit_s) begin
            match_d = 1'b1;
        end else if (mmio_wr_s && (off_s == OFF_STAT) && bus.ByteEnable[0] && bus.MemWData[0]) begin
            match_d = 1'b0;
        end else begin
            match_d = match_q;
        end

        if (mmio_wr_s && (off_s == OFF_LED) && bus.ByteEnable[0]) begin
            led_d = bus.MemWData[7:0];
        end else begin
            led_d = led_q;
        end

        if (!ctrl_d[0] || !ctrl_q[0] || tick_s) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    // Sticky unmapped-access flag; MemAddr is judged every cycle, not only on loads.
    always_comb begin
`ifdef DBUS_ERR_CHECK_EN
        bus_err_d = bus_err_q | unmapped_s;
`else
        bus_err_d = 1'b0;
`endif
    end

    // Register update with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= 32'h0000_0000;
            cmp_q     <= 32'h0000_0000;
            ctrl_q    <= 3'b000;
            match_q   <= 1'b0;
            led_q     <= 8'h00;
            pre_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            cmp_q     <= cmp_d;
            ctrl_q    <= ctrl_d;
            match_q   <= match_d;
            led_q     <= led_d;
            pre_q     <= pre_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Combinational read mux so a load completes within the CPU cycle.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (ram_hit_s) begin
            rdata_s = ram_q[ram_idx_s];
        end else if (mmio_hit_s) begin
            case (off_s)
                OFF_CNT:  rdata_s = cnt_q;
                OFF_CMP:  rdata_s = cmp_q;
                OFF_CTRL: rdata_s = {29'h0000_0000, ctrl_q};
                OFF_STAT: rdata_s = {31'h0000_0000, match_q};
                OFF_LED:  rdata_s = {24'h00_0000, led_q};
                default:  rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = UNMAPPED_RD;
        end
    end

    assign bus.MemRData = rdata_s;
    assign timer_irq    = match_q & ctrl_q[2];
    assign led          = led_q;
    assign bus_err      = bus_err_q;
endmodule

// File: tb/tb_rv32i_dbus_responder.sv
// Self-checking bench for rv32i_dbus_responder: directed scenarios plus random traffic vs a behavioural model.
module tb_rv32i_dbus_responder;
    localparam int          PRESCALE  = 4;
    localparam logic [31:0] RAM_BASE  = 32'h1000_0000;
    localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
    localparam logic [31:0] A_CNT  = MMIO_BASE + 32'h00;
    localparam logic [31:0] A_CMP  = MMIO_BASE + 32'h04;
    localparam logic [31:0] A_CTRL = MMIO_BASE + 32'h08;
    localparam logic [31:0] A_STAT = MMIO_BASE + 32'h0C;
    localparam logic [31:0] A_LED  = MMIO_BASE + 32'h10;
`ifdef DBUS_ERR_CHECK_EN
    localparam logic [31:0] UNMAPPED_VAL = 32'hDEAD_BEEF;
    localparam logic        ERR_ON       = 1'b1;
`else
    localparam logic [31:0] UNMAPPED_VAL = 32'h0000_0000;
    localparam logic        ERR_ON       = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       timer_irq;
    logic [7:0] led;
    logic       bus_err;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    rv32i_dbus_responder_if bus ();

    rv32i_dbus_responder #(
        .RAM_AW(10), .RAM_BASE(RAM_BASE), .MMIO_BASE(MMIO_BASE), .PRESCALE(PRESCALE)
    ) u_dut (
        .clk(clk), .reset(reset), .bus(bus), .timer_irq(timer_irq), .led(led), .bus_err(bus_err)
    );

    // Reference model state, updated once per rising edge from the architectural rules.
    logic [31:0] m_ram [int];
    logic [31:0] m_cnt, m_cmp;
    logic [2:0]  m_ctrl;
    logic        m_match, m_berr;
    logic [7:0]  m_led;
    int          m_pre;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic in_ram(input logic [31:0] a);
        return (a & 32'hFFFF_F000) == RAM_BASE;
    endfunction

    function automatic logic in_mmio(input logic [31:0] a);
        return (a & 32'hFFFF_FF00) == MMIO_BASE;
    endfunction

    function automatic logic [31:0] put_lanes(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic bit exp_read(input logic [31:0] a, output logic [31:0] v);
        int k;
        v = 32'h0;
        if (in_ram(a)) begin
            k = int'((a - RAM_BASE) >> 2);
            if (m_ram.exists(k)) begin
                v = m_ram[k];
                return 1'b1;
            end
            return 1'b0;
        end
        if (in_mmio(a)) begin
            case (a & 32'h0000_00FC)
                32'h00:  v = m_cnt;
                32'h04:  v = m_cmp;
                32'h08:  v = {29'h0, m_ctrl};
                32'h0C:  v = {31'h0, m_match};
                32'h10:  v = {24'h0, m_led};
                default: v = 32'h0;
            endcase
            return 1'b1;
        end
        v = UNMAPPED_VAL;
        return 1'b1;
    endfunction

    function automatic bit tick_next();
        return m_ctrl[0] && (m_pre == PRESCALE - 1);
    endfunction

    task automatic model_update(input logic rst, input logic we, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] off, n_cnt;
        logic [2:0]  n_ctrl;
        logic        tick, hit, mw;
        int          k;
        if (rst) begin
            m_cnt = 0; m_cmp = 0; m_ctrl = 0; m_match = 0; m_led = 0; m_pre = 0; m_berr = 0;
            return;
        end
        off  = a & 32'h0000_00FC;
        mw   = we && in_mmio(a);
        tick = tick_next();
        hit  = tick && (m_cnt == m_cmp);
        n_cnt = m_cnt;
        if (tick) n_cnt = (hit && m_ctrl[1]) ? 32'h0 : m_cnt + 32'h1;
        if (mw && off == 32'h00 && be != 4'h0) n_cnt = put_lanes(m_cnt, wd, be);
        if (mw && off == 32'h04) m_cmp = put_lanes(m_cmp, wd, be);
        n_ctrl = (mw && off == 32'h08 && be[0]) ? wd[2:0] : m_ctrl;
        if (mw && off == 32'h0C && be[0] && wd[0]) m_match = 1'b0;
        if (hit) m_match = 1'b1;
        if (mw && off == 32'h10 && be[0]) m_led = wd[7:0];
        m_pre = m_ctrl[0] ? (m_pre + 1) % PRESCALE : 0;
        if (!n_ctrl[0]) m_pre = 0;
        m_ctrl = n_ctrl;
        m_cnt  = n_cnt;
        if (we && in_ram(a)) begin
            k = int'((a - RAM_BASE) >> 2);
            if (be == 4'hF) m_ram[k] = wd;
            else if (m_ram.exists(k)) m_ram[k] = put_lanes(m_ram[k], wd, be);
        end
        if (ERR_ON && !in_ram(a) && !in_mmio(a)) m_berr = 1'b1;
    endtask

    task automatic drive(input logic rst, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] v;
        reset = rst; bus.MemWrite = we; bus.MemAddr = a; bus.MemWData = wd; bus.ByteEnable = be;
        #1;
        if (exp_read(a, v)) chk("rdata", bus.MemRData, v);
    endtask

    task automatic finish_edge(input logic rst, input logic we, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] be);
        @(posedge clk);
        model_update(rst, we, a, wd, be);
        #1;
        chk("timer_irq", {31'h0, timer_irq}, {31'h0, m_match & m_ctrl[2]});
        chk("led", {24'h0, led}, {24'h0, m_led});
        chk("bus_err", {31'h0, bus_err}, {31'h0, m_berr});
    endtask

    task automatic step(input logic rst, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
        drive(rst, we, a, wd, be);
        finish_edge(rst, we, a, wd, be);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        step(1'b0, 1'b1, a, wd, be);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, A_CNT, 32'h0, 4'h0);
    endtask

    task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] exp);
        drive(1'b0, 1'b0, a, 32'h0, 4'h0);
        chk(tag, bus.MemRData, exp);
        finish_edge(1'b0, 1'b0, a, 32'h0, 4'h0);
    endtask

    task automatic wait_tick(input bit need_hit);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            if (tick_next() && (!need_hit || m_cnt == m_cmp)) found = 1'b1;
            else idle(1);
        end
        chk("tick_found", {31'h0, found}, 32'h1);
    endtask

    initial begin
        logic [31:0] a, wd;
        logic [3:0]  be;
        logic        we;
        int          sel;
        m_cnt = 0; m_cmp = 0; m_ctrl = 0; m_match = 0; m_led = 0; m_pre = 0; m_berr = 0;

        step(1'b1, 1'b0, A_CNT, 32'h0, 4'h0);
        step(1'b1, 1'b0, A_CNT, 32'h0, 4'h0);
        rd(A_CNT,  "rst_cnt",  32'h0);
        rd(A_CMP,  "rst_cmp",  32'h0);
        rd(A_CTRL, "rst_ctrl", 32'h0);
        rd(A_STAT, "rst_stat", 32'h0);
        rd(A_LED,  "rst_ledreg", 32'h0);
        chk("rst_irq", {31'h0, timer_irq}, 32'h0);

        wr(32'h1000_0010, 32'h1122_3344, 4'b1111);
        wr(32'h1000_0010, 32'hAABB_CCDD, 4'b0100);
        rd(32'h1000_0010, "ram_be", 32'h11BB_3344);
        rd(32'h1000_0013, "ram_lowbits", 32'h11BB_3344);
        wr(32'h1000_0010, 32'h5566_7788, 4'b0000);
        rd(32'h1000_0010, "ram_be0_noop", 32'h11BB_3344);

        wr(A_CMP, 32'h3, 4'hF);
        wr(A_CTRL, 32'h1, 4'hF);
        idle(3);
        rd(A_CNT, "tick_cnt0", 32'h0);
        rd(A_CNT, "tick_cnt1", 32'h1);
        idle(10);
        rd(A_STAT, "stat_pre", 32'h0);
        rd(A_CNT, "cnt_after_match", 32'h4);
        rd(A_STAT, "stat_match", 32'h1);

        wr(A_CTRL, 32'h7, 4'hF);
        wr(A_CNT, 32'h0, 4'hF);
        wr(A_CMP, 32'h2, 4'hF);
        wr(A_STAT, 32'h1, 4'h1);
        idle(40);
        chk("irq_after_match", {31'h0, timer_irq}, 32'h1);
        wait_tick(1'b1);
        wr(A_STAT, 32'h1, 4'h1);
        rd(A_STAT, "w1c_vs_set", 32'h1);
        wr(A_STAT, 32'h1, 4'h1);
        rd(A_STAT, "w1c_clear", 32'h0);
        chk("irq_cleared", {31'h0, timer_irq}, 32'h0);

        wait_tick(1'b0);
        wr(A_CNT, 32'h0000_0100, 4'hF);
        rd(A_CNT, "cnt_write_wins", 32'h0000_0100);
        wr(A_CTRL, 32'h1, 4'hF);
        wr(A_CNT, 32'hFFFF_FFFF, 4'hF);
        wait_tick(1'b0);
        idle(1);
        rd(A_CNT, "cnt_wrap", 32'h0);

        wr(A_LED, 32'h0000_005A, 4'h1);
        chk("led_5a", {24'h0, led}, 32'h5A);
        wr(MMIO_BASE + 32'h14, 32'hFFFF_FFFF, 4'hF);
        rd(MMIO_BASE + 32'h14, "reserved_off", 32'h0);
        rd(32'h2000_0000, "unmapped_rd", UNMAPPED_VAL);
        chk("bus_err_flag", {31'h0, bus_err}, {31'h0, ERR_ON});

        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 4)      a = RAM_BASE + 32'(4 * (16 + $urandom_range(0, 15)));
            else if (sel < 9) a = MMIO_BASE + 32'(4 * $urandom_range(0, 7));
            else              a = 32'h2000_0000 + ($urandom & 32'h0000_0FFC);
            a  = a | 32'($urandom_range(0, 3));
            wd = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
            be = 4'($urandom_range(0, 15));
            we = 1'($urandom_range(0, 1));
            step(1'b0, we, a, wd, be);
        end

        wr(A_LED, 32'hFF, 4'h1);
        wr(A_CMP, 32'h0, 4'hF);
        wr(A_CNT, 32'h0, 4'hF);
        wr(A_CTRL, 32'h5, 4'hF);
        idle(6);
        rd(A_STAT, "pre_reset_match", 32'h1);
        step(1'b1, 1'b1, A_LED, 32'h33, 4'h1);
        rd(A_CNT,  "post_rst_cnt",  32'h0);
        rd(A_STAT, "post_rst_stat", 32'h0);
        chk("post_rst_irq", {31'h0, timer_irq}, 32'h0);
        chk("post_rst_led", {24'h0, led}, 32'h0);
        chk("post_rst_berr", {31'h0, bus_err}, 32'h0);
        rd(32'h1000_0010, "ram_survives_rst", 32'h11BB_3344);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
